// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Brief   : Encodes field-level ARM-subset instruction descriptors into 32-bit
//           words and streams them into instruction memory from word 0.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_alu,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic              in_i,
    input  logic              in_load,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [11:0]       in_imm,
    input  logic [23:0]       in_boff,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0]      c_idle  = 2'd0;
    localparam logic [1:0]      c_run   = 2'd1;
    localparam logic [1:0]      c_done  = 2'd2;
    localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_last  = c_depth - 1'b1;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;

    logic [3:0]  w_cmd;
    logic        w_alu_ok;
    logic        w_is_cmp;
    logic        w_invalid;
    logic        w_accept;
    logic [31:0] w_word;

    always_comb begin
        w_cmd    = 4'b0000;
        w_alu_ok = 1'b1;
        case (in_alu)
            3'd0:    w_cmd = 4'b0000;
            3'd1:    w_cmd = 4'b0010;
            3'd2:    w_cmd = 4'b0100;
            3'd3:    w_cmd = 4'b1100;
            3'd4:    w_cmd = 4'b1010;
            default: w_alu_ok = 1'b0;
        endcase
    end

    assign w_is_cmp  = (in_alu == 3'd4);
    assign w_invalid = (in_class == 2'b11) || ((in_class == 2'b00) && !w_alu_ok);

    // CMP has no destination and always updates flags
    always_comb begin
        w_word = 32'h0000_0000;
        case (in_class)
            2'b00:   w_word = {in_cond, 2'b00, in_i, w_cmd, in_s | w_is_cmp, in_rn,
                               w_is_cmp ? 4'h0 : in_rd,
                               in_i ? in_imm : {8'h00, in_rm}};
            2'b01:   w_word = {in_cond, 7'b0101100, in_load, in_rn, in_rd, in_imm};
            2'b10:   w_word = {in_cond, 4'b1010, in_boff};
            default: w_word = 32'h0000_0000;
        endcase
    end

    assign in_ready = (r_state == c_run) && (r_count < c_depth) && !finish;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_run: begin
                    if (finish) begin
                        r_state <= c_done;
                        r_done  <= 1'b1;
                    end else if (w_accept) begin
                        if (w_invalid) begin
                            r_err <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + 1'b1;
                            if (r_count == c_last) begin
                                r_state <= c_done;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_state <= c_run;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module  : tb_instr_encoder
// Brief   : Scoreboard bench for instr_encoder: directed vectors, randomized
//           descriptor streams, a 4-word instance, finish and reset corners.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid;
    logic [1:0]  in_class;
    logic [2:0]  in_alu;
    logic [3:0]  in_cond, in_rd, in_rn, in_rm;
    logic        in_s, in_i, in_load;
    logic [11:0] in_imm;
    logic [23:0] in_boff;

    logic        in_ready, imem_we, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        s_start, s_valid, s_ready, s_we, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_count = 0;
    int m_err = 0;
    logic [63:0] exp_q[$];
    logic [1:0]  s_addr_q[$];
    logic [31:0] s_data_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) u_dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_alu(in_alu), .in_cond(in_cond), .in_s(in_s), .in_i(in_i),
        .in_load(in_load), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .in_boff(in_boff), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .done(done), .err(err)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .finish(1'b0),
        .in_valid(s_valid), .in_ready(s_ready), .in_class(in_class),
        .in_alu(in_alu), .in_cond(in_cond), .in_s(in_s), .in_i(in_i),
        .in_load(in_load), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .in_boff(in_boff), .imem_we(s_we),
        .imem_addr(s_addr), .imem_wdata(s_wdata), .count(s_count),
        .done(s_done), .err(s_err)
    );

    // Reference encoder: bit 32 = descriptor valid, [31:0] = machine word
    function automatic logic [32:0] ref_word(
        input int unsigned cls, alu, cond, s, i, ld, rd, rn, rm, imm, boff);
        int unsigned cmds[5] = '{0, 2, 4, 12, 10};
        int unsigned w;
        if (cls == 3 || (cls == 0 && alu > 4)) return 33'h0;
        w = cond << 28;
        if (cls == 0) begin
            if (alu == 4) w += (i << 25) + (cmds[alu] << 21) + (1 << 20) + (rn << 16) + (i ? imm : rm);
            else          w += (i << 25) + (cmds[alu] << 21) + (s << 20) + (rn << 16) + (rd << 12) + (i ? imm : rm);
        end else if (cls == 1) begin
            w += (1 << 26) + (1 << 24) + (1 << 23) + (ld << 20) + (rn << 16) + (rd << 12) + imm;
        end else begin
            w += (10 << 24) + boff;
        end
        return {1'b1, w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_write: addr %h data %h with nothing expected", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), e[63:32]);
                chk("write_data", imem_wdata, e[31:0]);
            end
        end
        if (s_we === 1'b1) begin
            s_addr_q.push_back(s_addr);
            s_data_q.push_back(s_wdata);
        end
    end

    task automatic set_desc(input int cls, alu, cond, s, i, ld, rd, rn, rm, imm, boff);
        in_class = 2'(cls);  in_alu = 3'(alu);  in_cond = 4'(cond);
        in_s = 1'(s);  in_i = 1'(i);  in_load = 1'(ld);
        in_rd = 4'(rd);  in_rn = 4'(rn);  in_rm = 4'(rm);
        in_imm = 12'(imm);  in_boff = 24'(boff);
    endtask

    // Offer the current descriptor to the main DUT and log the expected outcome
    task automatic xfer();
        logic [32:0] r;
        int n;
        r = ref_word(in_class, in_alu, in_cond, in_s, in_i, in_load,
                     in_rd, in_rn, in_rm, in_imm, in_boff);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        @(posedge clk);
        if (r[32]) begin
            exp_q.push_back({32'(m_count), r[31:0]});
            m_count++;
        end else begin
            m_err = 1;
        end
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_count = 0;
        m_err = 0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic [32:0] r;
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        s_start = 1'b0; s_valid = 1'b0;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1;

        // Single ADD with immediate, write latency of one cycle
        pulse_start();
        chk("start_ready", 32'(in_ready), 1);
        set_desc(0, 2, 14, 0, 1, 0, 1, 2, 0, 5, 0);
        xfer();
        in_valid = 1'b0;
        chk("add_we", 32'(imem_we), 1);
        chk("add_addr", 32'(imem_addr), 0);
        chk("add_word", imem_wdata, 32'hE282_1005);
        chk("add_count", 32'(count), 1);
        @(posedge clk); #1;
        chk("strobe_one_cycle", 32'(imem_we), 0);
        chk("wdata_hold", imem_wdata, 32'hE282_1005);

        // Back-to-back vectors in a fresh session
        pulse_finish();
        chk("finish_done", 32'(done), 1);
        pulse_start();
        chk("restart_done", 32'(done), 0);
        chk("restart_count", 32'(count), 0);
        set_desc(0, 1, 14, 1, 0, 0, 3, 3, 4, 0, 0);        xfer();
        set_desc(0, 4, 14, 0, 1, 0, 7, 0, 0, 0, 0);        xfer();
        set_desc(1, 0, 14, 0, 0, 1, 2, 0, 0, 8, 0);        xfer();
        set_desc(1, 0, 14, 0, 0, 0, 2, 0, 0, 8, 0);        xfer();
        set_desc(2, 0, 14, 0, 0, 0, 0, 0, 0, 0, 'hFFFFFE); xfer();
        chk("b2b_count", 32'(count), 5);

        // Invalid ALU op between two valid descriptors
        set_desc(0, 5, 14, 0, 1, 0, 1, 1, 0, 3, 0);        xfer();
        set_desc(0, 3, 1, 1, 0, 0, 9, 8, 7, 0, 0);         xfer();
        in_valid = 1'b0;
        chk("inv_err", 32'(err), 1);
        chk("inv_count", 32'(count), 32'(m_count));

        // finish beats a simultaneous valid descriptor
        @(posedge clk); #1;
        set_desc(0, 2, 14, 0, 1, 0, 1, 2, 0, 5, 0);
        in_valid = 1'b1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        in_valid = 1'b0;
        chk("fin_done", 32'(done), 1);
        chk("fin_no_we", 32'(imem_we), 0);
        chk("fin_count", 32'(count), 32'(m_count));
        pulse_start();
        chk("fin_restart_count", 32'(count), 0);
        chk("fin_restart_err", 32'(err), 0);
        set_desc(0, 0, 0, 1, 0, 0, 5, 6, 2, 0, 0);         xfer();
        in_valid = 1'b0;

        // Randomized stream, restarting whenever memory fills
        for (int k = 0; k < 150; k++) begin
            if (m_count == 64) begin
                chk("full_done", 32'(done), 1);
                chk("full_ready", 32'(in_ready), 0);
                pulse_start();
            end
            set_desc($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 4095), $urandom_range(0, 24'hFFFFFF));
            xfer();
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (k % 25 == 24) begin
                chk("rand_count", 32'(count), 32'(m_count));
                chk("rand_err", 32'(err), 32'(m_err));
            end
        end
        in_valid = 1'b0;

        // Four-word instance: fifth descriptor is never taken
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            set_desc(0, 2, 14, 0, 1, 0, 1, 2, 0, k, 0);
            s_valid = 1'b1;
            n = 0;
            while (!s_ready && n < 3) begin
                @(posedge clk); #1;
                n++;
            end
            if (s_ready) begin
                @(posedge clk); #1;
                acc++;
            end
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("small_accepts", 32'(acc), 4);
        chk("small_writes", 32'(s_addr_q.size()), 4);
        for (int j = 0; j < 4 && j < s_addr_q.size(); j++) begin
            r = ref_word(0, 2, 14, 0, 1, 0, 1, 2, 0, j, 0);
            chk("small_addr", 32'(s_addr_q[j]), 32'(j));
            chk("small_data", s_data_q[j], r[31:0]);
        end
        chk("small_done", 32'(s_done), 1);
        chk("small_ready", 32'(s_ready), 0);
        chk("small_count", 32'(s_count), 4);

        // Asynchronous reset in the cycle after an accept
        pulse_finish();
        pulse_start();
        set_desc(1, 0, 14, 0, 0, 1, 4, 5, 0, 'h10, 0);
        xfer();
        in_valid = 1'b0;
        chk("pre_rst_we", 32'(imem_we), 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_we", 32'(imem_we), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
